// File: rtl/alu_defs.sv
// ============================================================================
// Module : alu_defs (package)
// Desc   : Opcode constants, FSM state encodings and default operand width
//          shared by the ALU UART front end and its benches.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_defs;

  localparam int BUS_DATOS_DEF = 8;

  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_SRA = 8'h03;

  typedef enum logic [2:0] {
    ST_ESPERA_A  = 3'd0,
    ST_ESPERA_OP = 3'd1,
    ST_ESPERA_B  = 3'd2,
    ST_CALCULO   = 3'd3,
    ST_ENVIO     = 3'd4,
    ST_ESPERA_TX = 3'd5
  } estado_t;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module : alu_core
// Desc   : Combinational ALU; unknown opcodes produce zero.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core
  import alu_defs::*;
#(
  parameter int BUS_DATOS = BUS_DATOS_DEF
) (
  input  logic [BUS_DATOS-1:0] a_i,
  input  logic [BUS_DATOS-1:0] b_i,
  input  logic [BUS_DATOS-1:0] op_i,
  output logic [BUS_DATOS-1:0] res_o
);

  logic signed [BUS_DATOS-1:0] w_a_s;
  logic                        w_shift_ovf;

  assign w_a_s       = $signed(a_i);
  // Shift amounts past the operand width saturate instead of relying on tool semantics.
  assign w_shift_ovf = (int'(b_i) >= BUS_DATOS);

  always_comb begin
    res_o = '0;
    case (op_i)
      BUS_DATOS'(OP_ADD): res_o = a_i + b_i;
      BUS_DATOS'(OP_SUB): res_o = a_i - b_i;
      BUS_DATOS'(OP_AND): res_o = a_i & b_i;
      BUS_DATOS'(OP_OR):  res_o = a_i | b_i;
      BUS_DATOS'(OP_XOR): res_o = a_i ^ b_i;
      BUS_DATOS'(OP_NOR): res_o = ~(a_i | b_i);
      BUS_DATOS'(OP_SRL): res_o = w_shift_ovf ? '0 : (a_i >> b_i);
      BUS_DATOS'(OP_SRA): res_o = w_shift_ovf ? {BUS_DATOS{a_i[BUS_DATOS-1]}}
                                              : $unsigned(w_a_s >>> b_i);
      default:            res_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_uart_interface.sv
// ============================================================================
// Module : alu_uart_interface
// Desc   : Collects A / opcode / B bytes from a UART receiver, computes the
//          result and hands it to a UART transmitter with a start pulse.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_uart_interface
  import alu_defs::*;
#(
  parameter int BUS_DATOS    = BUS_DATOS_DEF,
  parameter int CANT_ESTADOS = 6
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic [BUS_DATOS-1:0]            i_rx_data,
  input  logic                            i_rx_done,
  input  logic                            i_tx_done,
  output logic [BUS_DATOS-1:0]            o_tx_data,
  output logic                            o_tx_start,
  output logic                            o_busy,
  output logic [$clog2(CANT_ESTADOS)-1:0] o_estado
);

  estado_t              estado_q, estado_d;
  logic [BUS_DATOS-1:0] a_q, a_d;
  logic [BUS_DATOS-1:0] op_q, op_d;
  logic [BUS_DATOS-1:0] b_q, b_d;
  logic [BUS_DATOS-1:0] tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 busy_q, busy_d;
  logic [BUS_DATOS-1:0] w_res;

  alu_core #(
    .BUS_DATOS (BUS_DATOS)
  ) u_alu_core (
    .a_i   (a_q),
    .b_i   (b_q),
    .op_i  (op_q),
    .res_o (w_res)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      estado_q   <= ST_ESPERA_A;
      a_q        <= '0;
      op_q       <= '0;
      b_q        <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      a_q        <= a_d;
      op_q       <= op_d;
      b_q        <= b_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
    end
  end

  // Receive strobes are only honoured in the three collection states.
  always_comb begin
    estado_d  = estado_q;
    a_d       = a_q;
    op_d      = op_q;
    b_d       = b_q;
    tx_data_d = tx_data_q;
    case (estado_q)
      ST_ESPERA_A: begin
        if (i_rx_done) begin
          a_d      = i_rx_data;
          estado_d = ST_ESPERA_OP;
        end
      end
      ST_ESPERA_OP: begin
        if (i_rx_done) begin
          op_d     = i_rx_data;
          estado_d = ST_ESPERA_B;
        end
      end
      ST_ESPERA_B: begin
        if (i_rx_done) begin
          b_d      = i_rx_data;
          estado_d = ST_CALCULO;
        end
      end
      ST_CALCULO: begin
        tx_data_d = w_res;
        estado_d  = ST_ENVIO;
      end
      ST_ENVIO: begin
        estado_d = ST_ESPERA_TX;
      end
      ST_ESPERA_TX: begin
        if (i_tx_done) begin
          estado_d = ST_ESPERA_A;
        end
      end
      default: begin
        estado_d = ST_ESPERA_A;
      end
    endcase
  end

  // Status flags are registered from the next state so they align with it.
  always_comb begin
    tx_start_d = (estado_d == ST_ENVIO);
    busy_d     = (estado_d == ST_CALCULO) || (estado_d == ST_ENVIO) ||
                 (estado_d == ST_ESPERA_TX);
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_estado   = estado_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_uart_interface.sv
// ============================================================================
// Module : tb_alu_uart_interface
// Desc   : Directed self-checking bench with a result scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_uart_interface;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic [2:0] estado;

  int         checks   = 0;
  int         errors   = 0;
  int         n_ops    = 0;
  int         n_pulses = 0;
  logic [7:0] exp_q[$];

  alu_uart_interface #(
    .BUS_DATOS    (8),
    .CANT_ESTADOS (6)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_rx_data  (rx_data),
    .i_rx_done  (rx_done),
    .i_tx_done  (tx_done),
    .o_tx_data  (tx_data),
    .o_tx_start (tx_start),
    .o_busy     (busy),
    .o_estado   (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] op,
                                         input logic [7:0] b);
    logic [7:0] r;
    int         sh;
    r  = 8'h00;
    sh = int'(b);
    case (op)
      8'h20: r = 8'((int'(a) + int'(b)) % 256);
      8'h22: r = 8'((int'(a) - int'(b) + 256) % 256);
      8'h24: r = a & b;
      8'h25: r = a | b;
      8'h26: r = a ^ b;
      8'h27: r = ~(a | b);
      8'h02: for (int i = 0; i < 8; i++) r[i] = (i + sh > 7) ? 1'b0 : a[i + sh];
      8'h03: for (int i = 0; i < 8; i++) r[i] = (i + sh > 7) ? a[7] : a[i + sh];
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      n_pulses++;
      chk("tx_start_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] op, input logic [7:0] b,
                        input logic [7:0] expv);
    exp_q.push_back(expv);
    n_ops++;
    send_byte(a);
    send_byte(op);
    send_byte(b);
    chk("estado_calculo", 32'(estado), 32'd3);
    chk("busy_calculo", 32'(busy), 32'd1);
    chk("start_early", 32'(tx_start), 32'd0);
    @(posedge clk); #1;
    chk("start_latency", 32'(tx_start), 32'd1);
    @(posedge clk); #1;
    chk("start_width", 32'(tx_start), 32'd0);
    chk("estado_espera_tx", 32'(estado), 32'd5);
    chk("data_held", 32'(tx_data), 32'(expv));
  endtask

  task automatic finish_tx();
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    chk("estado_after_tx", 32'(estado), 32'd0);
    chk("busy_after_tx", 32'(busy), 32'd0);
  endtask

  logic [7:0] sweep_ops [9] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03, 8'h99};

  initial begin
    rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    #2;
    chk("rst_estado", 32'(estado), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(8'h05, 8'h20, 8'h03, 8'h08);
    repeat (2) @(posedge clk);
    #1 chk("wait_tx_hold", 32'(estado), 32'd5);
    finish_tx();

    run_op(8'h01, 8'h22, 8'h02, 8'hFF); finish_tx();
    run_op(8'h90, 8'h03, 8'h02, 8'hE4); finish_tx();
    run_op(8'h90, 8'h03, 8'h0A, 8'hFF); finish_tx();
    run_op(8'h90, 8'h02, 8'h0A, 8'h00); finish_tx();
    run_op(8'hD5, 8'h11, 8'h05, 8'h00); finish_tx();

    // tx_done outside ESPERA_TX must be ignored.
    send_byte(8'h41);
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    chk("tx_done_ignored", 32'(estado), 32'd1);
    send_byte(8'h20);
    send_byte(8'h01);
    exp_q.push_back(8'h42);
    n_ops++;
    repeat (2) @(posedge clk);
    #1 chk("estado_after_ignored", 32'(estado), 32'd5);
    finish_tx();

    run_op(8'h33, 8'h25, 8'h44, 8'h77);
    send_byte(8'hAA);
    chk("drop_busy_estado", 32'(estado), 32'd5);
    chk("drop_busy_data", 32'(tx_data), 32'h77);
    rx_data = 8'h55;
    rx_done = 1'b1;
    tx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    tx_done = 1'b0;
    chk("simul_strobes", 32'(estado), 32'd0);
    run_op(8'h0C, 8'h24, 8'h0A, 8'h08); finish_tx();

    send_byte(8'h33);
    send_byte(8'h20);
    chk("pre_reset_estado", 32'(estado), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_estado", 32'(estado), 32'd0);
    chk("async_rst_data", 32'(tx_data), 32'd0);
    chk("async_rst_start", 32'(tx_start), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_op(8'h0F, 8'h27, 8'hF0, 8'h00); finish_tx();

    foreach (sweep_ops[i]) begin
      run_op(8'h0D, sweep_ops[i], 8'h05, ref_alu(8'h0D, sweep_ops[i], 8'h05));
      finish_tx();
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("pulse_count", 32'(n_pulses), 32'(n_ops));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_uart_interface.md
# alu_uart_interface

Byte-serial front end for the ALU that sits between a UART receiver and a UART transmitter. It collects operand A, an opcode byte and operand B from successive receive strobes. It computes the result one cycle later and hands the result byte to the transmitter with a start pulse. It waits for the transmitter's done strobe before accepting the next operation.

## Interface
Parameters:
- BUS_DATOS, 8, width of operands, opcode byte and result.
- CANT_ESTADOS, 6, number of FSM states; sets the o_estado width (3 bits).

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_data  in  BUS_DATOS  received byte; valid only while i_rx_done=1.
- i_rx_done  in  1  one-cycle strobe, new byte on i_rx_data.
- i_tx_done  in  1  one-cycle strobe, transmitter finished the byte.
- o_tx_data  out  BUS_DATOS  result byte; held stable from o_tx_start until the next result.
- o_tx_start  out  1  one-cycle pulse requesting transmission.
- o_busy  out  1  high from CALCULO through ESPERA_TX.
- o_estado  out  3  current FSM state encoding, for debug LEDs.

## Operation
- Opcodes (i_rx_data at opcode step):
  - ADD 8'h20, SUB 8'h22, AND 8'h24, OR 8'h25, XOR 8'h26, NOR 8'h27.
  - SRL 8'h02, SRA 8'h03.
  - Any other value is an invalid opcode; its result is 0.
- Arithmetic and width rules:
  - ADD and SUB wrap modulo 2^BUS_DATOS; the carry/borrow is discarded.
  - Operands are unsigned, except that SRA treats A as signed.
  - Shifts are A shifted by B, with B read as unsigned.
  - Shift amount ≥ BUS_DATOS: SRL gives 0; SRA gives all bits equal to A's MSB.
- FSM states, encoded 0–5:
  - ESPERA_A: on i_rx_done, register A and go to ESPERA_OP.
  - ESPERA_OP: on i_rx_done, register the opcode and go to ESPERA_B.
  - ESPERA_B: on i_rx_done, register B and go to CALCULO.
  - CALCULO: register the ALU result into o_tx_data, then go to ENVIO.
  - ENVIO: o_tx_start=1 for this cycle only, then go to ESPERA_TX.
  - ESPERA_TX: on i_tx_done, go to ESPERA_A; otherwise stay.
- Boundary conditions:
  - i_rx_done in CALCULO, ENVIO or ESPERA_TX: the byte is dropped and no state changes.
  - i_tx_done outside ESPERA_TX: ignored.
  - i_rx_done and i_tx_done in the same cycle in ESPERA_TX: i_tx_done is honoured, the byte is dropped, and the next state is ESPERA_A.
- Reset, asynchronous, including mid-operation:
  - State returns to ESPERA_A; A, B and opcode clear to 0.
  - o_tx_data=0, o_tx_start=0, o_busy=0, o_estado=0.
  - No partial operation survives reset.

## Timing
- All state and outputs are registered on the rising edge of i_clock.
- Strobe accepted at edge N, with i_rx_done sampled high: the state advances at edge N.
- i_rx_done for B sampled at edge N:
  - state=CALCULO after edge N;
  - o_tx_data valid after edge N+1;
  - o_tx_start high during the cycle after edge N+1, low after edge N+2.
- Latency from the B strobe to the o_tx_start pulse is 2 cycles.
- o_tx_data becomes valid in the same cycle o_tx_start rises and does not change until the next CALCULO.
- Back-to-back operations: A can be accepted on the first i_rx_done sampled after the i_tx_done edge.
- Minimum period per operation: 3 receive strobes + 2 cycles + transmitter time.

## Structure
- Shared package or header (`alu_defs`): opcode constants, FSM state encodings, default BUS_DATOS. The ALU testbenches use the same package.
- Sub-module `alu_core`: purely combinational, inputs A, B and opcode, output result. It implements the opcode table above, returns 0 for invalid opcodes, and is parameterised on BUS_DATOS.
- The top level holds only the FSM and registers.

## Test plan
- Basic ADD: after reset release, send 8'h05, 8'h20, 8'h03 → one o_tx_start pulse 2 cycles after the third strobe, with o_tx_data=8'h08. After i_tx_done, o_estado=0.
- Wrap and SRA:
  - 8'h01, 8'h22, 8'h02 → 8'hFF.
  - 8'h90, 8'h03, 8'h02 → 8'hE4.
  - 8'h90, 8'h03, 8'h0A → 8'hFF.
  - 8'h90, 8'h02, 8'h0A → 8'h00.
- Invalid opcode: 8'hD5, 8'h11, 8'h05 → o_tx_data=8'h00, still exactly one o_tx_start pulse.
- Drop while busy and simultaneous strobes:
  - Extra i_rx_done during ESPERA_TX → no change to A or state.
  - i_rx_done together with i_tx_done → return to ESPERA_A, and the next operation (8'h0C, 8'h24, 8'h0A) yields 8'h08.
- Reset mid-operation: assert i_reset low in ESPERA_B → all outputs 0 immediately, without waiting for a clock edge. After release, sending 8'h0F, 8'h27, 8'hF0 yields 8'h00, with no stale operand.
- Full table sweep: A=8'h0D, B=8'h05 through every opcode → compare each result against a reference model, one o_tx_start per operation, no spurious pulses.
